// File: rtl/sdram_init_checker.sv
// Passive monitor of the SDRAM power-up command sequence (PRECHARGE ALL, AUTO REFRESH, LOAD MODE).
// Optional macro SDRAM_CHK_MODE_EN additionally requires the loaded mode word to equal MODE_EXP.
module sdram_init_checker #(
  parameter int unsigned T_POWER  = 20000,
  parameter int unsigned T_RP     = 2,
  parameter int unsigned T_RC     = 7,
  parameter int unsigned T_MRD    = 3,
  parameter int unsigned AREF_MIN = 2,
  parameter logic [12:0] MODE_EXP = 13'h037
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  init_cmd,
  input  logic [1:0]  init_ba,
  input  logic [12:0] init_addr,
  input  logic        init_end,
  output logic        chk_ok,
  output logic        chk_err,
  output logic [2:0]  err_code,
  output logic [3:0]  aref_cnt,
  output logic [14:0] mode_reg,
  output logic        mode_vld
);

  typedef enum logic [2:0] {PWR, PRE, AREF, MRD, DONE, ERR} state_e;
  typedef enum logic [2:0] {CMD_NOP, CMD_PRE, CMD_AREF, CMD_LMR, CMD_ILL} cmd_e;

  state_e      state, state_nxt;
  cmd_e        cmd;
  logic [15:0] cnt;
  logic        err_set;
  logic [2:0]  err_val;
  logic        aref_inc, mode_cap, ok_set;
  logic        first_aref, pwr_ok, gap_ok, mrd_ok, aref_ok, mode_bad;

  // cs_n high (DESELECT) is treated exactly like NOP
  always_comb begin
    cmd = CMD_ILL;
    if (init_cmd[3]) begin
      cmd = CMD_NOP;
    end else begin
      case (init_cmd[2:0])
        3'b111:  cmd = CMD_NOP;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_AREF;
        3'b000:  cmd = CMD_LMR;
        default: cmd = CMD_ILL;
      endcase
    end
  end

  assign first_aref = (aref_cnt == 4'd0);
  assign pwr_ok     = 32'(cnt) >= T_POWER;
  assign gap_ok     = first_aref ? (32'(cnt) >= T_RP) : (32'(cnt) >= T_RC);
  assign mrd_ok     = 32'(cnt) >= T_MRD;
  assign aref_ok    = 32'(aref_cnt) >= AREF_MIN;

`ifdef SDRAM_CHK_MODE_EN
  assign mode_bad = ({init_ba, init_addr} != {2'b00, MODE_EXP});
`else
  logic unused_mode_exp;
  assign mode_bad        = 1'b0;
  assign unused_mode_exp = ^MODE_EXP;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= PWR;
    else         state <= state_nxt;
  end

  // Branches are ordered so that the lowest error code wins when several apply
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    err_val   = '0;
    case (state)
      PWR: begin
        if (cmd != CMD_NOP) begin
          if (!pwr_ok) begin
            err_set = 1'b1;
            err_val = 3'd1;
          end else if (cmd == CMD_PRE && init_addr[10]) begin
            state_nxt = AREF;
          end else begin
            err_set = 1'b1;
            err_val = 3'd2;
          end
        end
      end
      AREF: begin
        case (cmd)
          CMD_NOP: ;
          CMD_AREF: begin
            if (!gap_ok) begin
              err_set = 1'b1;
              err_val = first_aref ? 3'd3 : 3'd4;
            end
          end
          CMD_LMR: begin
            if (!gap_ok) begin
              err_set = 1'b1;
              err_val = first_aref ? 3'd3 : 3'd4;
            end else if (!aref_ok) begin
              err_set = 1'b1;
              err_val = 3'd5;
            end else if (mode_bad) begin
              err_set = 1'b1;
              err_val = 3'd6;
            end else begin
              state_nxt = MRD;
            end
          end
          default: begin
            err_set = 1'b1;
            err_val = 3'd2;
          end
        endcase
      end
      MRD: begin
        if (cmd != CMD_NOP) begin
          err_set = 1'b1;
          err_val = 3'd2;
        end else if (mrd_ok) begin
          state_nxt = DONE;
        end
      end
      PRE:     state_nxt = PWR;
      default: ;
    endcase

    if (init_end && !err_set && (state inside {PWR, PRE, AREF, MRD}) &&
        !(state == MRD && mrd_ok)) begin
      err_set = 1'b1;
      err_val = 3'd7;
    end

    if (err_set) state_nxt = ERR;
  end

  // A rejected mode word (code 6) is still captured for inspection
  always_comb begin
    aref_inc = (state == AREF) && (cmd == CMD_AREF) && !err_set;
    mode_cap = (state == AREF) && (cmd == CMD_LMR) &&
               ((state_nxt == MRD) || (err_set && err_val == 3'd6));
    ok_set   = (state == MRD) && (state_nxt == DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt      <= '0;
      aref_cnt <= '0;
      mode_reg <= '0;
      mode_vld <= 1'b0;
      chk_ok   <= 1'b0;
      chk_err  <= 1'b0;
      err_code <= '0;
    end else begin
      if (cmd != CMD_NOP)  cnt <= 16'd1;
      else if (cnt != '1)  cnt <= cnt + 16'd1;

      if (aref_inc && aref_cnt != '1) aref_cnt <= aref_cnt + 4'd1;

      if (mode_cap) begin
        mode_reg <= {init_ba, init_addr};
        mode_vld <= 1'b1;
      end

      if (ok_set) chk_ok <= 1'b1;

      if (err_set) begin
        chk_err  <= 1'b1;
        err_code <= err_val;
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_checker.sv
// Directed vector bench for sdram_init_checker; power-up wait shortened to TP cycles.
`timescale 1ns/1ps
module tb_sdram_init_checker;

  localparam int TP = 1000;

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_DSL  = 4'b1000;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;
  localparam logic [3:0] C_LMR  = 4'b0000;
  localparam logic [3:0] C_ACT  = 4'b0011;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [3:0]  init_cmd = C_NOP;
  logic [1:0]  init_ba = '0;
  logic [12:0] init_addr = '0;
  logic        init_end = 1'b0;
  logic        chk_ok, chk_err, mode_vld;
  logic [2:0]  err_code;
  logic [3:0]  aref_cnt;
  logic [14:0] mode_reg;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_init_checker #(.T_POWER(TP)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .init_cmd (init_cmd),
    .init_ba  (init_ba),
    .init_addr(init_addr),
    .init_end (init_end),
    .chk_ok   (chk_ok),
    .chk_err  (chk_err),
    .err_code (err_code),
    .aref_cnt (aref_cnt),
    .mode_reg (mode_reg),
    .mode_vld (mode_vld)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic        ie;
    int          nb;
    logic [24:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [24:0] outs();
    return {chk_ok, chk_err, err_code, aref_cnt, mode_vld, mode_reg};
  endfunction

  task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got ok/err/code/aref/vld/mode=%b/%b/%0d/%0d/%b/%h, expected %b/%b/%0d/%0d/%b/%h",
               name, act[24], act[23], act[22:20], act[19:16], act[15], act[14:0],
               exp[24], exp[23], exp[22:20], exp[19:16], exp[15], exp[14:0]);
    end
  endtask

  task automatic add(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic ie, input int nb, input logic ok, input logic err,
                     input logic [2:0] code, input logic [3:0] ar, input logic vld,
                     input logic [14:0] mode);
    vec_t v;
    v.rst = 1'b0; v.cmd = c; v.ba = b; v.addr = a; v.ie = ie; v.nb = nb;
    v.exp = {ok, err, code, ar, vld, mode};
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    vec_t v;
    v.rst = 1'b1; v.cmd = C_NOP; v.ba = '0; v.addr = '0; v.ie = 1'b0; v.nb = 0;
    v.exp = '0;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a, input logic ie);
    @(negedge sys_clk);
    sys_rst = 1'b0; init_cmd = c; init_ba = b; init_addr = a; init_end = ie;
    @(posedge sys_clk); #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1; init_cmd = C_NOP; init_ba = '0; init_addr = '0; init_end = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) cyc(C_NOP, 2'b00, 13'h0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Clean sequence: 8 refreshes, mode word, init_end after tMRD; DONE ignores later activity
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    for (int k = 2; k <= 8; k++) add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 4'(k), 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 6, 0, 0, 0, 8, 1, 15'h0037);
    add(C_NOP, 0, 13'h0, 1, 2, 1, 0, 0, 8, 1, 15'h0037);
    add(C_ACT, 0, 13'h0, 0, 0, 1, 0, 0, 8, 1, 15'h0037);
    add(C_NOP, 0, 13'h0, 1, 0, 1, 0, 0, 8, 1, 15'h0037);
    // Early PRECHARGE, then frozen
    add_rst();
    add(C_PRE, 0, 13'h400, 0, 100, 0, 1, 1, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 0, 0, 1, 1, 0, 0, 15'h0);
    add(C_NOP, 0, 13'h0, 1, 0, 0, 1, 1, 0, 0, 15'h0);
    // tRP violation
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 0, 0, 1, 3, 0, 0, 15'h0);
    // tRC violation, then aref_cnt frozen
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 5, 0, 1, 4, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 1, 4, 1, 0, 15'h0);
    // Too few refreshes
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 6, 0, 1, 5, 1, 0, 15'h0);
    // Codes 4 and 5 together: 4 wins
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 5, 0, 1, 4, 1, 0, 15'h0);
    // Codes 3 and 5 together: 3 wins
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 0, 0, 1, 3, 0, 0, 15'h0);
    // ACTIVE after PRECHARGE
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_ACT, 0, 13'h0, 0, 1, 0, 1, 2, 0, 0, 15'h0);
    // init_end during power-up wait
    add_rst();
    add(C_NOP, 0, 13'h0, 1, 499, 0, 1, 7, 0, 0, 15'h0);
    // PRECHARGE without addr[10]
    add_rst();
    add(C_PRE, 0, 13'h000, 0, TP, 0, 1, 2, 0, 0, 15'h0);
    // Command one cycle short of the power-up wait
    add_rst();
    add(C_AREF, 0, 13'h0, 0, TP - 1, 0, 1, 1, 0, 0, 15'h0);
    // Legal PRECHARGE with init_end: code 7; early PRECHARGE with init_end: code 1
    add_rst();
    add(C_PRE, 0, 13'h400, 1, TP, 0, 1, 7, 0, 0, 15'h0);
    add_rst();
    add(C_PRE, 0, 13'h400, 1, TP - 1, 0, 1, 1, 0, 0, 15'h0);
    // DESELECT counts as NOP; reset mid-sequence; clean rerun
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_DSL, 0, 13'h0, 0, 5, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 0, 0, 0, 0, 2, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 3, 0, 15'h0);
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 2, 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 6, 0, 0, 0, 2, 1, 15'h0037);
    add(C_NOP, 0, 13'h0, 1, 2, 1, 0, 0, 2, 1, 15'h0037);
    // init_end before tMRD elapsed; bank bits captured in mode_reg
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 2, 0, 15'h0);
`ifdef SDRAM_CHK_MODE_EN
    add(C_LMR, 2'b11, 13'h037, 0, 6, 0, 1, 6, 2, 1, 15'h6037);
    add(C_NOP, 0, 13'h0, 1, 1, 0, 1, 6, 2, 1, 15'h6037);
`else
    add(C_LMR, 2'b11, 13'h037, 0, 6, 0, 0, 0, 2, 1, 15'h6037);
    add(C_NOP, 0, 13'h0, 1, 1, 0, 1, 7, 2, 1, 15'h6037);
`endif
    // Command during tMRD
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 2, 0, 15'h0);
    add(C_LMR, 0, 13'h037, 0, 6, 0, 0, 0, 2, 1, 15'h0037);
    add(C_PRE, 0, 13'h400, 0, 0, 0, 1, 2, 2, 1, 15'h0037);
    // Non-default mode word
    add_rst();
    add(C_PRE, 0, 13'h400, 0, TP, 0, 0, 0, 0, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 1, 0, 0, 0, 1, 0, 15'h0);
    add(C_AREF, 0, 13'h0, 0, 6, 0, 0, 0, 2, 0, 15'h0);
`ifdef SDRAM_CHK_MODE_EN
    add(C_LMR, 0, 13'h032, 0, 6, 0, 1, 6, 2, 1, 15'h0032);
    add(C_NOP, 0, 13'h0, 1, 2, 0, 1, 6, 2, 1, 15'h0032);
`else
    add(C_LMR, 0, 13'h032, 0, 6, 0, 0, 0, 2, 1, 15'h0032);
    add(C_NOP, 0, 13'h0, 1, 2, 1, 0, 0, 2, 1, 15'h0032);
`endif

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        nops(tbl[i].nb);
        cyc(tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].ie);
      end
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // chk_err rises only after the edge that samples the offending command
    do_reset();
    nops(99);
    @(negedge sys_clk);
    init_cmd = C_PRE; init_addr = 13'h400;
    #1;
    check("latency_before", {24'h0, chk_err}, 25'h0);
    @(posedge sys_clk); #1;
    check("latency_after", {21'h0, chk_err, err_code}, {21'h0, 1'b1, 3'd1});

    // aref_cnt saturation, then chk_ok exactly when cnt reaches T_MRD
    do_reset();
    nops(TP);
    cyc(C_PRE, 2'b00, 13'h400, 1'b0);
    nops(1);
    cyc(C_AREF, 2'b00, 13'h0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      nops(6);
      cyc(C_AREF, 2'b00, 13'h0, 1'b0);
    end
    check("aref_sat", outs(), {1'b0, 1'b0, 3'd0, 4'd15, 1'b0, 15'h0});
    nops(6);
    cyc(C_LMR, 2'b00, 13'h037, 1'b0);
    check("sat_lmr", outs(), {1'b0, 1'b0, 3'd0, 4'd15, 1'b1, 15'h0037});
    nops(1);
    check("mrd_cnt1", outs(), {1'b0, 1'b0, 3'd0, 4'd15, 1'b1, 15'h0037});
    nops(1);
    check("mrd_cnt2", outs(), {1'b0, 1'b0, 3'd0, 4'd15, 1'b1, 15'h0037});
    nops(1);
    check("mrd_done", outs(), {1'b1, 1'b0, 3'd0, 4'd15, 1'b1, 15'h0037});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_init_checker.md
Name: sdram_init_checker

Overview:
- Passive responder on the SDRAM command bus: decodes {cs_n,ras_n,cas_n,we_n}, ba and addr driven by the SDRAM init controller.
- Checks the JEDEC power-up sequence against timing parameters: power-up wait, PRECHARGE ALL, tRP, N x AUTO REFRESH with tRC spacing, LOAD MODE REGISTER, tMRD.
- Reports pass/fail, error code and the captured mode word.
- Sits beside the SDRAM model in simulation and as an on-chip sanity monitor in hardware bring-up; it never drives the bus.

Parameters:
- T_POWER, 20000, minimum cycles from reset release to the first non-NOP command (200 us at 100 MHz).
- T_RP, 2, minimum cycles from PRECHARGE to the next command.
- T_RC, 7, minimum cycles from AUTO REFRESH to the next command.
- T_MRD, 3, minimum cycles from LOAD MODE to DONE / init_end.
- AREF_MIN, 2, minimum AUTO REFRESH count before LOAD MODE.
- MODE_EXP, 13'h037, expected mode word (used only with the optional feature).

Ports:
- sys_clk  in  1  command-bus clock (100 MHz).
- sys_rst  in  1  synchronous, active-high reset.
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n}.
- init_ba  in  2  bank address.
- init_addr  in  13  address bus.
- init_end  in  1  controller's done flag.
- chk_ok  out  1  sequence passed; sticky.
- chk_err  out  1  violation detected; sticky.
- err_code  out  3  first violation code.
- aref_cnt  out  4  AUTO REFRESH count, saturates at 15.
- mode_reg  out  15  {ba,addr} captured at LOAD MODE.
- mode_vld  out  1  mode_reg holds a captured word.

Behaviour:
- Decode: cs_n=1 is DESELECT and counts as NOP. 0111 NOP, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 LOAD MODE. Anything else (ACTIVE/READ/WRITE/BST) is illegal before DONE.
- Gap counter cnt, 16 bits, saturating:
  - Reset to 0.
  - On any non-NOP command, next value is 1; otherwise increments each cycle.
  - A command is timing-legal when cnt >= the required minimum in the same cycle.
- States: PWR, PRE, AREF, MRD, DONE, ERR. Reset enters PWR.
- PWR: NOP stays. Any non-NOP with cnt < T_POWER -> ERR code 1. PRECHARGE with addr[10]=1 and cnt >= T_POWER -> AREF. Any other command -> ERR code 2.
- PRE (reserved alias): PRECHARGE is handled in PWR; the state encoding keeps PRE for a single-step debug view and is otherwise unused.
- AREF, on AUTO REFRESH:
  - Required gap is T_RP if aref_cnt=0, else T_RC.
  - Violation -> ERR code 3 (after PRECHARGE) or code 4 (after a refresh).
  - Otherwise aref_cnt increments.
- AREF, on LOAD MODE:
  - Requires aref_cnt >= AREF_MIN, else ERR code 5.
  - Requires gap >= T_RC (or T_RP if aref_cnt=0), else code 4/3.
  - On pass: mode_reg <= {init_ba,init_addr}, mode_vld <= 1, state -> MRD.
- AREF, any other non-NOP -> ERR code 2.
- MRD: any non-NOP -> ERR code 2. cnt >= T_MRD -> DONE; chk_ok is asserted the cycle after entry.
- init_end rule: init_end=1 in any state other than DONE or MRD-with-cnt>=T_MRD -> ERR code 7. This is checked at lower priority than command checks in the same cycle.
- DONE and ERR are terminal until reset. DONE ignores all bus activity. In ERR, err_code and aref_cnt freeze.
- Simultaneous violations: lowest code wins. Only the first error is recorded.
- Reset values: chk_ok=0, chk_err=0, err_code=0, aref_cnt=0, mode_reg=0, mode_vld=0, cnt=0.
- Reset mid-sequence clears everything and restarts the power-up wait.
- All outputs are registered; one cycle of latency from the offending command to chk_err.

Optional Feature:
- Macro SDRAM_CHK_MODE_EN.
- When defined: at LOAD MODE, if {init_ba,init_addr} != {2'b00,MODE_EXP}, go to ERR with code 6. mode_reg still captures the value.
- When undefined: any mode word is accepted, and code 6 never occurs.

Test Plan:
- Clean sequence: NOPs to cycle 20000, PRECHARGE addr=0x400, AREF at +2, then 7 more AREFs at 7-cycle gaps, LMR 0x037 at +7, init_end at +3 -> chk_ok=1, aref_cnt=8, mode_reg=0x0037, chk_err=0.
- PRECHARGE at cycle 100 -> chk_err=1, err_code=1 one cycle later.
- PRECHARGE at 20000, AREF 1 cycle later -> err_code=3. Separately, a second AREF 6 cycles after the first -> err_code=4.
- Single AREF then LMR with AREF_MIN=2 -> err_code=5, mode_vld=0. Separately, ACTIVE (0011) after PRECHARGE -> err_code=2.
- init_end pulsed at cycle 500 -> err_code=7. Separately, sys_rst during AREF state with aref_cnt=3 -> all outputs 0, then a clean sequence passes.
- With SDRAM_CHK_MODE_EN: LMR 0x032 -> err_code=6, mode_reg=0x0032. Without the macro, the same stimulus gives chk_ok=1.
